// File: rtl/mae_pkg.sv
// Shared widths and latency helpers for the mae_behav multiply/accumulate slice.
// Holds operand/result widths and path latency functions of the register parameters.
package mae_pkg;

  localparam int MAE_A_W = 18;
  localparam int MAE_B_W = 18;
  localparam int MAE_M_W = MAE_A_W + MAE_B_W;
  localparam int MAE_P_W = 40;

  // Cycles from A (or B) to P.
  function automatic int mae_lat_a(
    input int bypass_a,
    input int mult_has_reg,
    input int bypass_p
  );
    return bypass_a + mult_has_reg + bypass_p;
  endfunction

  // Cycles from C to P.
  function automatic int mae_lat_c(
    input int bypass_c,
    input int bypass_p
  );
    return bypass_c + bypass_p;
  endfunction

endpackage

// File: rtl/mae_pipe_reg.sv
// Optional pipeline register: enable-gated, async active-low reset, or a plain wire.
// Ports: clk, rst_n, en (load enable), d (input), q (output); PRESENT=0 makes q=d.
module mae_pipe_reg #(
  parameter int W       = 1,
  parameter int PRESENT = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  if (PRESENT != 0) begin : g_reg
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        q <= '0;
      end else if (en) begin
        q <= d;
      end
    end
  end else begin : g_wire
    logic unused_ok;
    assign unused_ok = &{1'b0, clk, rst_n, en};
    assign q = d;
  end

endmodule

// File: rtl/mae_behav.sv
// Signed 18x18 multiplier with optional post-adder, P feedback and per-stage registers.
// Ports: CLK, ARST_N, A/B/C with enables, CDIN_FDBK_SEL, P_EN, P; OVF when MAE_BEHAV_OVF_EN.
module mae_behav
  import mae_pkg::*;
#(
  parameter int BYPASS_A          = 0,
  parameter int BYPASS_B          = 0,
  parameter int BYPASS_C          = 0,
  parameter int BYPASS_P          = 0,
  parameter int MULT_HAS_REG      = 0,
  parameter int POST_ADDER_STATIC = 0,
  parameter int USE_FEEDBACK      = 0
) (
  input  logic               CLK,
  input  logic               ARST_N,
  input  logic [MAE_A_W-1:0] A,
  input  logic               A_EN,
  input  logic [MAE_B_W-1:0] B,
  input  logic               B_EN,
  input  logic [MAE_P_W-1:0] C,
  input  logic               C_EN,
  input  logic               CDIN_FDBK_SEL,
  input  logic               P_EN,
  output logic [MAE_P_W-1:0] P
`ifdef MAE_BEHAV_OVF_EN
  ,
  output logic               OVF
`endif
);

  // Feedback needs a real P register and an active post-adder.
  if (USE_FEEDBACK != 0 &&
      (BYPASS_P == 0 || POST_ADDER_STATIC == 0)) begin : g_bad_cfg
    $error("mae_behav: USE_FEEDBACK needs BYPASS_P=1 and POST_ADDER_STATIC=1");
  end

  logic [MAE_A_W-1:0] a_q;
  logic [MAE_B_W-1:0] b_q;
  logic [MAE_P_W-1:0] c_q;
  logic [MAE_M_W-1:0] a_x;
  logic [MAE_M_W-1:0] b_x;
  logic [MAE_M_W-1:0] prod;
  logic [MAE_P_W-1:0] prod_ext;
  logic [MAE_P_W-1:0] m_q;
  logic [MAE_P_W-1:0] fb_val;
  logic [MAE_P_W-1:0] addend;
  logic [MAE_P_W-1:0] sum;
  logic [MAE_P_W-1:0] p_q;

  mae_pipe_reg #(.W(MAE_A_W), .PRESENT(BYPASS_A)) u_a (
    .clk(CLK), .rst_n(ARST_N), .en(A_EN), .d(A), .q(a_q)
  );

  mae_pipe_reg #(.W(MAE_B_W), .PRESENT(BYPASS_B)) u_b (
    .clk(CLK), .rst_n(ARST_N), .en(B_EN), .d(B), .q(b_q)
  );

  mae_pipe_reg #(.W(MAE_P_W), .PRESENT(BYPASS_C)) u_c (
    .clk(CLK), .rst_n(ARST_N), .en(C_EN), .d(C), .q(c_q)
  );

  // Sign-extend to the full product width so the low 36 bits are exact.
  assign a_x      = {{(MAE_M_W-MAE_A_W){a_q[MAE_A_W-1]}}, a_q};
  assign b_x      = {{(MAE_M_W-MAE_B_W){b_q[MAE_B_W-1]}}, b_q};
  assign prod     = a_x * b_x;
  assign prod_ext = {{(MAE_P_W-MAE_M_W){prod[MAE_M_W-1]}}, prod};

  mae_pipe_reg #(.W(MAE_P_W), .PRESENT(MULT_HAS_REG)) u_m (
    .clk(CLK), .rst_n(ARST_N), .en(P_EN), .d(prod_ext), .q(m_q)
  );

  // Feedback is only wired when enabled, so no loop exists otherwise.
  if (USE_FEEDBACK != 0) begin : g_fb
    assign fb_val = CDIN_FDBK_SEL ? p_q : c_q;
  end else begin : g_nofb
    assign fb_val = c_q;
  end

  always_comb begin
    addend = '0;
    if (POST_ADDER_STATIC != 0) begin
      addend = fb_val;
    end
  end

  assign sum = m_q + addend;

  mae_pipe_reg #(.W(MAE_P_W), .PRESENT(BYPASS_P)) u_p (
    .clk(CLK), .rst_n(ARST_N), .en(P_EN), .d(sum), .q(p_q)
  );

  assign P = p_q;

`ifdef MAE_BEHAV_OVF_EN
  logic ovf_c;

  // Operands agree in sign but the result does not.
  assign ovf_c = (m_q[MAE_P_W-1] == addend[MAE_P_W-1]) &&
                 (sum[MAE_P_W-1] != m_q[MAE_P_W-1]);

  mae_pipe_reg #(.W(1), .PRESENT(BYPASS_P)) u_ovf (
    .clk(CLK), .rst_n(ARST_N), .en(P_EN), .d(ovf_c), .q(OVF)
  );
`endif

  logic unused_ok;
  assign unused_ok = &{1'b0, c_q, fb_val, CDIN_FDBK_SEL};

endmodule

// File: tb/tb_mae_behav.sv
// Randomized and directed bench for mae_behav over four legal configurations.
// A value-level model per instance is compared with every DUT on each falling edge.
module tb_mae_behav;
  import mae_pkg::*;

  localparam int NI = 4;
  // 0: combinational, 1: pipelined product, 2: MAC, 3: registered C adder
  localparam int CBA [NI] = '{0, 1, 0, 0};
  localparam int CBB [NI] = '{0, 1, 0, 1};
  localparam int CBC [NI] = '{0, 0, 0, 1};
  localparam int CBP [NI] = '{0, 1, 1, 0};
  localparam int CMR [NI] = '{0, 1, 0, 1};
  localparam int CPA [NI] = '{0, 0, 1, 1};
  localparam int CFB [NI] = '{0, 0, 1, 0};

  logic        CLK = 1'b0;
  logic        ARST_N = 1'b0;
  logic [17:0] A = '0;
  logic        A_EN = 1'b0;
  logic [17:0] B = '0;
  logic        B_EN = 1'b0;
  logic [39:0] C = '0;
  logic        C_EN = 1'b0;
  logic        SEL = 1'b0;
  logic        P_EN = 1'b0;
  logic [39:0] p_dut [NI];
  logic        ovf_dut [NI];

  int n_checks = 0;
  int n_fail = 0;

  initial forever #5 CLK = ~CLK;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    mae_behav #(
      .BYPASS_A(CBA[g]), .BYPASS_B(CBB[g]), .BYPASS_C(CBC[g]),
      .BYPASS_P(CBP[g]), .MULT_HAS_REG(CMR[g]),
      .POST_ADDER_STATIC(CPA[g]), .USE_FEEDBACK(CFB[g])
    ) u_dut (
      .CLK(CLK), .ARST_N(ARST_N),
      .A(A), .A_EN(A_EN), .B(B), .B_EN(B_EN),
      .C(C), .C_EN(C_EN), .CDIN_FDBK_SEL(SEL),
      .P_EN(P_EN), .P(p_dut[g])
`ifdef MAE_BEHAV_OVF_EN
      , .OVF(ovf_dut[g])
`endif
    );
`ifndef MAE_BEHAV_OVF_EN
    assign ovf_dut[g] = 1'b0;
`endif
  end

  // Model: values last captured by each enabled stage.
  longint ha [NI] = '{0, 0, 0, 0};
  longint hb [NI] = '{0, 0, 0, 0};
  longint hc [NI] = '{0, 0, 0, 0};
  longint hm [NI] = '{0, 0, 0, 0};
  longint hp [NI] = '{0, 0, 0, 0};
  bit     ho [NI] = '{0, 0, 0, 0};

  function automatic longint w40(input longint v);
    logic [39:0] t;
    t = v[39:0];
    return longint'($signed(t));
  endfunction

  function automatic void mdl_eval(
    input  int     i,
    output longint pv,
    output bit     ov,
    output bit     ovc,
    output longint prod,
    output longint sum
  );
    longint a, b, c, m, add, raw;
    a = (CBA[i] != 0) ? ha[i] : longint'($signed(A));
    b = (CBB[i] != 0) ? hb[i] : longint'($signed(B));
    c = (CBC[i] != 0) ? hc[i] : longint'($signed(C));
    prod = a * b;
    m = (CMR[i] != 0) ? hm[i] : prod;
    add = 0;
    if (CPA[i] != 0) add = (CFB[i] != 0 && SEL) ? hp[i] : c;
    raw = m + add;
    sum = w40(raw);
    ovc = (raw > 64'sd549755813887) || (raw < -64'sd549755813888);
    pv = (CBP[i] != 0) ? hp[i] : sum;
    ov = (CBP[i] != 0) ? ho[i] : ovc;
  endfunction

  always @(negedge ARST_N) begin
    for (int i = 0; i < NI; i++) begin
      ha[i] = 0; hb[i] = 0; hc[i] = 0;
      hm[i] = 0; hp[i] = 0; ho[i] = 0;
    end
  end

  always @(posedge CLK) begin
    if (ARST_N) begin
      for (int i = 0; i < NI; i++) begin
        longint pv, prod, sum;
        bit ov, ovc;
        mdl_eval(i, pv, ov, ovc, prod, sum);
        if (A_EN) ha[i] = longint'($signed(A));
        if (B_EN) hb[i] = longint'($signed(B));
        if (C_EN) hc[i] = longint'($signed(C));
        if (P_EN) begin
          hm[i] = prod;
          hp[i] = sum;
          ho[i] = ovc;
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [39:0] act,
                     input logic [39:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge CLK) begin
    for (int i = 0; i < NI; i++) begin
      longint pv, prod, sum;
      bit ov, ovc;
      mdl_eval(i, pv, ov, ovc, prod, sum);
      chk($sformatf("model_p%0d", i), p_dut[i], pv[39:0]);
`ifdef MAE_BEHAV_OVF_EN
      chk($sformatf("model_ovf%0d", i), {39'b0, ovf_dut[i]}, {39'b0, ov});
`endif
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    #12 ARST_N = 1'b1;

    // Combinational instance: same-cycle product, C ignored.
    A = 18'd3;
    B = 18'h3FFFC;
    C = 40'h12_3456_789A;
    #1 chk("comb_p", p_dut[0], 40'hFF_FFFF_FFF4);
    chk("rst_pipe_p", p_dut[1], 40'h0);
    chk("rst_mac_p", p_dut[2], 40'h0);

    // Pipelined product: 3-cycle A-to-P latency.
    A = 18'd100;
    B = 18'd200;
    C = 40'h0;
    A_EN = 1'b1; B_EN = 1'b1; C_EN = 1'b1; P_EN = 1'b1;
    SEL = 1'b0;
    tick();
    chk("pipe_lat1", p_dut[1], 40'h0);
    tick();
    chk("pipe_lat2", p_dut[1], 40'h0);
    tick();
    chk("pipe_lat3", p_dut[1], 40'd20000);

    // MAC: load, accumulate, hold.
    A = 18'd2;
    B = 18'd2;
    C = 40'd5;
    SEL = 1'b0;
    tick();
    chk("mac_load", p_dut[2], 40'd9);
    SEL = 1'b1;
    tick();
    chk("mac_acc1", p_dut[2], 40'd13);
    tick();
    chk("mac_acc2", p_dut[2], 40'd17);
    tick();
    chk("mac_acc3", p_dut[2], 40'd21);
    P_EN = 1'b0;
    tick();
    chk("mac_hold", p_dut[2], 40'd21);

    // Async reset mid-accumulation, then restart from feedback 0.
    #2 ARST_N = 1'b0;
    #1 chk("mac_async_rst", p_dut[2], 40'h0);
    chk("pipe_async_rst", p_dut[1], 40'h0);
    #4 ARST_N = 1'b1;
    SEL = 1'b1;
    A = 18'd1;
    B = 18'd1;
    P_EN = 1'b1;
    tick();
    chk("mac_after_rst", p_dut[2], 40'd1);

    // Wrap: 2^34 per load; crosses 2^39 at load 32, back to 0 at 64.
    #1 ARST_N = 1'b0;
    #2 ARST_N = 1'b1;
    A = 18'h20000;
    B = 18'h20000;
    C = 40'h0;
    SEL = 1'b0;
    tick();
    chk("wrap_first", p_dut[2], 40'h04_0000_0000);
    SEL = 1'b1;
    repeat (31) tick();
    chk("wrap_signed", p_dut[2], 40'h80_0000_0000);
`ifdef MAE_BEHAV_OVF_EN
    chk("wrap_ovf", {39'b0, ovf_dut[2]}, 40'h1);
`endif
    tick();
`ifdef MAE_BEHAV_OVF_EN
    chk("wrap_ovf_clear", {39'b0, ovf_dut[2]}, 40'h0);
`endif
    repeat (31) tick();
    chk("wrap_zero", p_dut[2], 40'h0);

    // Randomized phase.
    for (int n = 0; n < 400; n++) begin
      A = 18'($urandom);
      B = 18'($urandom);
      if ($urandom_range(7) == 0) A = 18'h20000;
      if ($urandom_range(7) == 0) B = 18'h20000;
      C = {8'($urandom), 32'($urandom)};
      A_EN = ($urandom_range(3) != 0);
      B_EN = ($urandom_range(3) != 0);
      C_EN = ($urandom_range(3) != 0);
      P_EN = ($urandom_range(3) != 0);
      SEL = ($urandom_range(3) != 0);
      tick();
      if ($urandom_range(39) == 0) begin
        #2 ARST_N = 1'b0;
        #2 ARST_N = 1'b1;
      end
    end

    @(negedge CLK);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
